gpio_ctrl_intr_filt: RTL and testbench

//  Next-generation GPIO interrupt detector. Synchronises and debounces every GPIO input, then detects

---
 rtl/gpio_ctrl_pkg.sv | 11 +
 rtl/gpio_ctrl_deb_cell.sv | 48 ++++
 rtl/gpio_ctrl_intr_filt.sv | 76 +++++++
 tb/tb_gpio_ctrl_intr_filt.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_ctrl_pkg.sv
// Shared defaults and types for the GPIO interrupt detector slice.
package gpio_ctrl_pkg;

    localparam int unsigned GPIO_NUM_DEFAULT   = 256;
    localparam int unsigned GROUP_SIZE_DEFAULT = 32;
    localparam int unsigned SYNC_STAGES_DEFAULT = 2;
    localparam int unsigned DEB_W_DEFAULT      = 8;

    typedef logic [DEB_W_DEFAULT-1:0] deb_cnt_t;

endpackage

// File: rtl/gpio_ctrl_deb_cell.sv
// One pin: synchroniser chain, debounce counter and filtered value with a one-cycle update strobe.
module gpio_ctrl_deb_cell
    import gpio_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int unsigned DEB_W       = DEB_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_pad,
    input  logic [DEB_W-1:0] i_deb_limit,
    output logic             o_sync,
    output logic             o_filt,
    output logic             o_upd
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES:0]   w_chain;
    logic                   r_filt;
    logic [DEB_W-1:0]       r_cnt;
    logic                   w_mismatch;

    // Concatenating the pad below the chain keeps the shift valid for a single stage too.
    assign w_chain    = {r_sync, i_pad};
    assign o_sync     = r_sync[SYNC_STAGES-1];
    assign o_filt     = r_filt;
    assign w_mismatch = o_sync != r_filt;
    assign o_upd      = w_mismatch && (r_cnt >= i_deb_limit);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_filt <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_sync <= w_chain[SYNC_STAGES-1:0];
            if (!w_mismatch) begin
                r_cnt <= '0;
            end else if (o_upd) begin
                r_filt <= o_sync;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpio_ctrl_intr_filt.sv
// GPIO interrupt detector: per-pin debounce cells, sticky W1C status and per-group interrupt OR.
module gpio_ctrl_intr_filt
    import gpio_ctrl_pkg::*;
#(
    parameter int unsigned NUM_GPIO    = GPIO_NUM_DEFAULT,
    parameter int unsigned GROUP_SIZE  = GROUP_SIZE_DEFAULT,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int unsigned DEB_W       = DEB_W_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_GPIO-1:0]          gpio_in_data,
    input  logic [DEB_W-1:0]             deb_limit,
    input  logic [NUM_GPIO-1:0]          posedge_intr_enable,
    input  logic [NUM_GPIO-1:0]          negedge_intr_enable,
    input  logic [NUM_GPIO-1:0]          level_intr_enable,
    input  logic [NUM_GPIO-1:0]          level_intr_polarity,
    input  logic [NUM_GPIO-1:0]          intr_status_clr,
    output logic [NUM_GPIO-1:0]          gpio_filt_data,
    output logic [NUM_GPIO-1:0]          intr_status,
    output logic [NUM_GPIO/GROUP_SIZE-1:0] group_intr
);

    localparam int unsigned NUM_GROUPS = NUM_GPIO / GROUP_SIZE;

    if ((GROUP_SIZE == 0) || ((NUM_GPIO % GROUP_SIZE) != 0)) begin : g_bad_group
        $error("NUM_GPIO must be a non-zero multiple of GROUP_SIZE");
    end
    if (SYNC_STAGES < 1) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 1");
    end

    logic [NUM_GPIO-1:0] w_sync;
    logic [NUM_GPIO-1:0] w_filt;
    logic [NUM_GPIO-1:0] w_upd;
    logic [NUM_GPIO-1:0] w_rise;
    logic [NUM_GPIO-1:0] w_fall;
    logic [NUM_GPIO-1:0] w_level;
    logic [NUM_GPIO-1:0] r_status;

    for (genvar p = 0; p < NUM_GPIO; p++) begin : g_pin
        gpio_ctrl_deb_cell #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEB_W      (DEB_W)
        ) u_cell (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_pad      (gpio_in_data[p]),
            .i_deb_limit(deb_limit),
            .o_sync     (w_sync[p]),
            .o_filt     (w_filt[p]),
            .o_upd      (w_upd[p])
        );
    end

    assign w_rise  = w_upd & w_sync & posedge_intr_enable;
    assign w_fall  = w_upd & ~w_sync & negedge_intr_enable;
    assign w_level = level_intr_enable & ~(w_filt ^ level_intr_polarity);

    // Sets are ORed after the clear so a same-cycle event keeps the bit set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_status <= '0;
        end else begin
            r_status <= (r_status & ~intr_status_clr) | w_rise | w_fall | w_level;
        end
    end

    assign gpio_filt_data = w_filt;
    assign intr_status    = r_status;

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_group
        assign group_intr[g] = |r_status[g*GROUP_SIZE +: GROUP_SIZE];
    end

endmodule

// File: tb/tb_gpio_ctrl_intr_filt.sv
// Directed bench for gpio_ctrl_intr_filt with hand-computed expectations.
module tb_gpio_ctrl_intr_filt;
    import gpio_ctrl_pkg::*;

    logic         clk;
    logic         rst_n;
    logic [255:0] gpio_in_data;
    deb_cnt_t     deb_limit;
    logic [255:0] posedge_intr_enable;
    logic [255:0] negedge_intr_enable;
    logic [255:0] level_intr_enable;
    logic [255:0] level_intr_polarity;
    logic [255:0] intr_status_clr;
    logic [255:0] gpio_filt_data;
    logic [255:0] intr_status;
    logic [7:0]   group_intr;

    int n_checks = 0;
    int n_fail   = 0;

    gpio_ctrl_intr_filt #(
        .NUM_GPIO   (256),
        .GROUP_SIZE (32),
        .SYNC_STAGES(2),
        .DEB_W      (8)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .gpio_in_data       (gpio_in_data),
        .deb_limit          (deb_limit),
        .posedge_intr_enable(posedge_intr_enable),
        .negedge_intr_enable(negedge_intr_enable),
        .level_intr_enable  (level_intr_enable),
        .level_intr_polarity(level_intr_polarity),
        .intr_status_clr    (intr_status_clr),
        .gpio_filt_data     (gpio_filt_data),
        .intr_status        (intr_status),
        .group_intr         (group_intr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] bit_at(input int unsigned idx);
        logic [255:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    initial begin
        rst_n               = 1'b0;
        gpio_in_data        = '0;
        deb_limit           = 8'd3;
        posedge_intr_enable = '0;
        negedge_intr_enable = '0;
        level_intr_enable   = '0;
        level_intr_polarity = '0;
        intr_status_clr     = '0;

        // Reset held with toggling pads
        for (int c = 0; c < 3; c++) begin
            gpio_in_data = ~gpio_in_data;
            tick(1);
            chk("rst_filt", gpio_filt_data, '0);
            chk("rst_status", intr_status, '0);
            chk("rst_group", {248'd0, group_intr}, '0);
        end
        rst_n        = 1'b1;
        gpio_in_data = '0;
        tick(1);
        chk("rel_filt", gpio_filt_data, '0);
        chk("rel_status", intr_status, '0);
        chk("rel_group", {248'd0, group_intr}, '0);

        // Pin 5 rising edge, deb_limit 3: accepted at edge 6
        posedge_intr_enable[5] = 1'b1;
        gpio_in_data[5]        = 1'b1;
        tick(5);
        chk("p5_filt_e5", gpio_filt_data, '0);
        chk("p5_status_e5", intr_status, '0);
        tick(1);
        chk("p5_filt_e6", gpio_filt_data, bit_at(5));
        chk("p5_status_e6", intr_status, bit_at(5));
        chk("p5_group_e6", {248'd0, group_intr}, 256'h01);
        intr_status_clr[5] = 1'b1;
        tick(1);
        intr_status_clr[5] = 1'b0;
        chk("p5_cleared", intr_status, '0);

        // Pin 40: 3-cycle pulse absorbed, 4-cycle pulse accepted
        posedge_intr_enable[40] = 1'b1;
        gpio_in_data[40]        = 1'b1;
        tick(3);
        gpio_in_data[40] = 1'b0;
        tick(6);
        chk("p40_short_filt", gpio_filt_data, bit_at(5));
        chk("p40_short_status", intr_status, '0);
        gpio_in_data[40] = 1'b1;
        tick(4);
        gpio_in_data[40] = 1'b0;
        tick(1);
        chk("p40_long_e5_filt", gpio_filt_data, bit_at(5));
        tick(1);
        chk("p40_long_filt", gpio_filt_data, bit_at(5) | bit_at(40));
        chk("p40_long_status", intr_status, bit_at(40));
        chk("p40_long_group", {248'd0, group_intr}, 256'h02);
        tick(10);
        chk("p40_back_low_filt", gpio_filt_data, bit_at(5));
        chk("p40_sticky", intr_status, bit_at(40));
        intr_status_clr[40] = 1'b1;
        tick(1);
        intr_status_clr[40] = 1'b0;
        chk("p40_cleared", intr_status, '0);

        // Pin 7, deb_limit 0: a set on the clear cycle wins, a lone clear then takes effect
        deb_limit              = 8'd0;
        posedge_intr_enable[7] = 1'b1;
        gpio_in_data[7]        = 1'b1;
        tick(2);
        chk("p7_rise_e2", intr_status, '0);
        tick(1);
        chk("p7_rise_e3", intr_status, bit_at(7));
        gpio_in_data[7] = 1'b0;
        tick(3);
        chk("p7_low_filt", gpio_filt_data, bit_at(5));
        chk("p7_low_status", intr_status, bit_at(7));
        gpio_in_data[7] = 1'b1;
        tick(2);
        intr_status_clr[7] = 1'b1;
        tick(1);
        chk("p7_set_vs_clr", intr_status, bit_at(7));
        chk("p7_refilt", gpio_filt_data, bit_at(5) | bit_at(7));
        tick(1);
        intr_status_clr[7] = 1'b0;
        chk("p7_clr_alone", intr_status, '0);

        // Pin 255 active-low level: uncleareable while active
        level_intr_enable[255]   = 1'b1;
        level_intr_polarity[255] = 1'b0;
        tick(1);
        chk("p255_level_set", intr_status, bit_at(255));
        chk("p255_group", {248'd0, group_intr}, 256'h80);
        intr_status_clr[255] = 1'b1;
        tick(1);
        intr_status_clr[255] = 1'b0;
        chk("p255_clr_blocked", intr_status, bit_at(255));
        chk("p255_group_held", {248'd0, group_intr}, 256'h80);
        gpio_in_data[255] = 1'b1;
        tick(4);
        chk("p255_sticky_inactive", intr_status, bit_at(255));
        intr_status_clr[255] = 1'b1;
        tick(1);
        intr_status_clr[255] = 1'b0;
        chk("p255_cleared", intr_status, '0);
        chk("p255_group_clr", {248'd0, group_intr}, '0);

        // Settle everything low with no enables
        posedge_intr_enable = '0;
        level_intr_enable   = '0;
        level_intr_polarity = '0;
        gpio_in_data        = '0;
        tick(6);
        chk("settle_filt", gpio_filt_data, '0);
        chk("settle_status", intr_status, '0);

        // Pin 0: reset mid-debounce discards the count
        deb_limit              = 8'd3;
        negedge_intr_enable[0] = 1'b1;
        level_intr_enable[100] = 1'b1;
        gpio_in_data[0]        = 1'b1;
        tick(6);
        chk("p0_high_filt", gpio_filt_data, bit_at(0));
        chk("p100_level", intr_status, bit_at(100));
        chk("p100_group", {248'd0, group_intr}, 256'h08);
        gpio_in_data[0] = 1'b0;
        tick(4);
        chk("p0_mid_deb_filt", gpio_filt_data, bit_at(0));
        rst_n             = 1'b0;
        level_intr_enable = '0;
        tick(1);
        rst_n = 1'b1;
        chk("mid_rst_filt", gpio_filt_data, '0);
        chk("mid_rst_status", intr_status, '0);
        chk("mid_rst_group", {248'd0, group_intr}, '0);
        tick(2);
        chk("post_rst_quiet", intr_status, '0);
        gpio_in_data[0] = 1'b1;
        tick(5);
        chk("p0_redeb_e5", gpio_filt_data, '0);
        tick(1);
        chk("p0_redeb_e6", gpio_filt_data, bit_at(0));
        chk("p0_no_rise_status", intr_status, '0);
        gpio_in_data[0] = 1'b0;
        tick(5);
        chk("p0_fall_e5", intr_status, '0);
        tick(1);
        chk("p0_fall_e6", intr_status, bit_at(0));
        chk("p0_fall_filt", gpio_filt_data, '0);
        chk("p0_fall_group", {248'd0, group_intr}, 256'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
